msm_scalar_slicer: RTL and testbench

Streaming scalar-decomposition stage that feeds the Pippenger multi-scalar-multiplication bucket accumulator of the FPGA SNARK prover. Each accepted (scalar, point index) pair is split into fixed-width windows. The stage emits one (window, digit, point index) beat per non-zero digit and skips zero digits at no cycle cost. The downstream bucket stage consumes these beats and adds point[idx] into bucket[window][digit].

---
 rtl/msm_scalar_slicer.sv | 175 +++++++++++++++++
 tb/tb_msm_scalar_slicer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msm_scalar_slicer.sv
// Splits each scalar into fixed-width windows and streams one beat per
// non-zero digit toward the Pippenger bucket accumulator.
module msm_scalar_slicer #(
    parameter int DAT_BITS    = 256,
    parameter int WINDOW_BITS = 8,
    parameter int IDX_BITS    = 16,
    localparam int NUM_WIN    = (DAT_BITS + WINDOW_BITS - 1) / WINDOW_BITS,
    localparam int WIN_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_val,
    output logic                   o_rdy,
    input  logic [DAT_BITS-1:0]    i_scalar,
    input  logic [IDX_BITS-1:0]    i_idx,
    input  logic                   i_last,
    output logic                   o_val,
    input  logic                   i_rdy,
    output logic [WIN_W-1:0]       o_win,
    output logic [WINDOW_BITS-1:0] o_digit,
    output logic [IDX_BITS-1:0]    o_idx,
    output logic                   o_last
);

    localparam int PAD_BITS = NUM_WIN * WINDOW_BITS;

    typedef enum logic [1:0] {
        S_RST,
        S_IDLE,
        S_SCAN
    } state_t;

    state_t                 state_q, state_d;
    logic [PAD_BITS-1:0]    scalar_q, scalar_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic                   last_q, last_d;
    logic [NUM_WIN-1:0]     mask_q, mask_d;
    logic                   rdy_q, rdy_d;
    logic                   val_q, val_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [WINDOW_BITS-1:0] digit_q, digit_d;
    logic [IDX_BITS-1:0]    oidx_q, oidx_d;
    logic                   olast_q, olast_d;

    logic [PAD_BITS-1:0]    in_pad;
    logic [NUM_WIN-1:0]     in_mask;
    logic [WIN_W-1:0]       sel;
    logic [WINDOW_BITS-1:0] sel_digit;
    logic [NUM_WIN-1:0]     mask_clr;
    logic                   out_free;

    // Top window is zero-extended when the scalar width is not a multiple.
    assign in_pad = PAD_BITS'(i_scalar);

    always_comb begin
        in_mask = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            in_mask[w] = |in_pad[w*WINDOW_BITS +: WINDOW_BITS];
        end
    end

    // Find-first-set: descending scan leaves the lowest set bit in sel.
    always_comb begin
        sel = '0;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if (mask_q[w]) begin
                sel = WIN_W'(w);
            end
        end
    end

    always_comb begin
        sel_digit = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (WIN_W'(w) == sel) begin
                sel_digit = scalar_q[w*WINDOW_BITS +: WINDOW_BITS];
            end
        end
    end

    assign mask_clr = mask_q & ~(NUM_WIN'(1) << sel);
    assign out_free = !val_q || i_rdy;

    always_comb begin
        state_d  = state_q;
        scalar_d = scalar_q;
        idx_d    = idx_q;
        last_d   = last_q;
        mask_d   = mask_q;
        val_d    = val_q && !i_rdy;
        win_d    = win_q;
        digit_d  = digit_q;
        oidx_d   = oidx_q;
        olast_d  = olast_q;
        unique case (state_q)
            S_RST: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (i_val && rdy_q) begin
                    scalar_d = in_pad;
                    idx_d    = i_idx;
                    last_d   = i_last;
                    mask_d   = in_mask;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    // Zero scalar still closes the vector with a no-op beat.
                    if (!last_q) begin
                        state_d = S_IDLE;
                    end else if (out_free) begin
                        val_d   = 1'b1;
                        win_d   = '0;
                        digit_d = '0;
                        oidx_d  = idx_q;
                        olast_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (out_free) begin
                    val_d   = 1'b1;
                    win_d   = sel;
                    digit_d = sel_digit;
                    oidx_d  = idx_q;
                    olast_d = last_q && (mask_clr == '0);
                    mask_d  = mask_clr;
                    if (mask_clr == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_RST;
            scalar_q <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            mask_q   <= '0;
            rdy_q    <= 1'b0;
            val_q    <= 1'b0;
            win_q    <= '0;
            digit_q  <= '0;
            oidx_q   <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            scalar_q <= scalar_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            mask_q   <= mask_d;
            rdy_q    <= rdy_d;
            val_q    <= val_d;
            win_q    <= win_d;
            digit_q  <= digit_d;
            oidx_q   <= oidx_d;
            olast_q  <= olast_d;
        end
    end

    assign o_rdy   = rdy_q;
    assign o_val   = val_q;
    assign o_win   = win_q;
    assign o_digit = digit_q;
    assign o_idx   = oidx_q;
    assign o_last  = olast_q;

endmodule

// File: tb/tb_msm_scalar_slicer.sv
// Directed and randomized checks of the scalar slicer on a 16-bit and a
// 10-bit (partial top window) configuration.
module tb_msm_scalar_slicer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] idx = '0;
    logic        last = 1'b0;
    logic        rdy = 1'b1;

    logic        v16 = 1'b0;
    logic [15:0] s16 = '0;
    logic        orv16, ov16, ol16;
    logic [1:0]  ow16;
    logic [3:0]  od16;
    logic [15:0] oi16;

    logic        v10 = 1'b0;
    logic [9:0]  s10 = '0;
    logic        orv10, ov10, ol10;
    logic [1:0]  ow10;
    logic [3:0]  od10;
    logic [15:0] oi10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msm_scalar_slicer #(.DAT_BITS(16), .WINDOW_BITS(4), .IDX_BITS(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(v16), .o_rdy(orv16),
        .i_scalar(s16), .i_idx(idx), .i_last(last), .o_val(ov16),
        .i_rdy(rdy), .o_win(ow16), .o_digit(od16), .o_idx(oi16),
        .o_last(ol16)
    );

    msm_scalar_slicer #(.DAT_BITS(10), .WINDOW_BITS(4), .IDX_BITS(16)) dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(v10), .o_rdy(orv10),
        .i_scalar(s10), .i_idx(idx), .i_last(last), .o_val(ov10),
        .i_rdy(rdy), .o_win(ow10), .o_digit(od10), .o_idx(oi10),
        .o_last(ol10)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat16(input string tag, input int w, input int d,
                          input int i, input int l);
        chk({tag, "_val"}, 32'(ov16), 1);
        chk({tag, "_win"}, 32'(ow16), w);
        chk({tag, "_dig"}, 32'(od16), d);
        chk({tag, "_idx"}, 32'(oi16), i);
        chk({tag, "_last"}, 32'(ol16), l);
    endtask

    task automatic beat10(input string tag, input int w, input int d,
                          input int i, input int l);
        chk({tag, "_val"}, 32'(ov10), 1);
        chk({tag, "_win"}, 32'(ow10), w);
        chk({tag, "_dig"}, 32'(od10), d);
        chk({tag, "_idx"}, 32'(oi10), i);
        chk({tag, "_last"}, 32'(ol10), l);
    endtask

    task automatic send16(input logic [15:0] s, input logic [15:0] i,
                          input logic l);
        logic acc;
        acc = 1'b0;
        s16 = s;
        idx = i;
        last = l;
        v16 = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = orv16;
            step;
        end
        v16 = 1'b0;
        chk("send16_accept", 32'(acc), 1);
    endtask

    task automatic send10(input logic [9:0] s, input logic [15:0] i,
                          input logic l);
        logic acc;
        acc = 1'b0;
        s10 = s;
        idx = i;
        last = l;
        v10 = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = orv10;
            step;
        end
        v10 = 1'b0;
        chk("send10_accept", 32'(acc), 1);
    endtask

    logic [22:0] q[$];
    logic [22:0] b[4];
    int          nb;
    int          sent;
    logic        pend;
    logic [15:0] sc;
    logic [15:0] rid;
    logic        lst;
    logic [3:0]  dg;

    initial begin
        step;
        step;
        chk("rst_rdy", 32'(orv16), 0);
        chk("rst_val", 32'(ov16), 0);
        chk("rst_win", 32'(ow16), 0);
        chk("rst_dig", 32'(od16), 0);
        chk("rst_idx", 32'(oi16), 0);
        chk("rst_last", 32'(ol16), 0);
        rst_n = 1'b1;
        chk("rdy_rstcyc", 32'(orv16), 0);
        step;
        chk("rdy_up16", 32'(orv16), 1);
        chk("rdy_up10", 32'(orv10), 1);

        // 0x30A1: digits 1, A, 0(skipped), 3
        send16(16'h30A1, 16'd5, 1'b0);
        chk("t1_latency", 32'(ov16), 0);
        step;
        beat16("t1b0", 0, 1, 5, 0);
        step;
        beat16("t1b1", 1, 10, 5, 0);
        step;
        beat16("t1b2", 3, 3, 5, 0);
        chk("t1_rdy_overlap", 32'(orv16), 1);
        step;
        chk("t1_drain", 32'(ov16), 0);

        send16(16'h0000, 16'd7, 1'b0);
        step;
        chk("t2_nobeat", 32'(ov16), 0);
        chk("t2_idle", 32'(orv16), 1);
        send16(16'h0000, 16'd9, 1'b1);
        step;
        beat16("t2b0", 0, 0, 9, 1);
        step;
        chk("t2_drain", 32'(ov16), 0);

        send10(10'h3FF, 16'd2, 1'b1);
        step;
        beat10("t3b0", 0, 15, 2, 0);
        step;
        beat10("t3b1", 1, 15, 2, 0);
        step;
        beat10("t3b2", 2, 3, 2, 1);
        step;
        chk("t3_drain", 32'(ov10), 0);

        send16(16'hFFFF, 16'd3, 1'b1);
        step;
        beat16("t4b0", 0, 15, 3, 0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            beat16("t4hold", 0, 15, 3, 0);
            chk("t4_rdy_low", 32'(orv16), 0);
        end
        rdy = 1'b1;
        step;
        beat16("t4b1", 1, 15, 3, 0);
        step;
        beat16("t4b2", 2, 15, 3, 0);
        step;
        beat16("t4b3", 3, 15, 3, 1);
        step;
        chk("t4_drain", 32'(ov16), 0);

        send16(16'hFFFF, 16'd4, 1'b1);
        step;
        beat16("t5b0", 0, 15, 4, 0);
        step;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_val", 32'(ov16), 0);
        chk("t5_async_rdy", 32'(orv16), 0);
        chk("t5_async_last", 32'(ol16), 0);
        step;
        rst_n = 1'b1;
        chk("t5_rstcyc", 32'(orv16), 0);
        step;
        chk("t5_rdy_back", 32'(orv16), 1);
        chk("t5_no_beat", 32'(ov16), 0);
        send16(16'h0001, 16'd6, 1'b1);
        step;
        beat16("t5b", 0, 1, 6, 1);
        step;
        chk("t5_drain", 32'(ov16), 0);

        sent = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 40000 && (sent < 1000 || q.size() != 0);
             cyc++) begin
            if (!pend && sent < 1000) begin
                for (int w = 0; w < 4; w++) begin
                    sc[w*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                                   : 4'($urandom_range(0, 15));
                end
                rid = 16'(sent);
                lst = ($urandom_range(0, 7) == 0);
                pend = 1'b1;
            end
            v16 = pend && ($urandom_range(0, 3) != 0);
            s16 = sc;
            idx = rid;
            last = lst;
            rdy = ($urandom_range(0, 3) != 0);
            if (ov16 && rdy) begin
                chk("rnd_expected_beat", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("rnd_beat", 32'({ow16, od16, oi16, ol16}),
                        32'(q.pop_front()));
                end
            end
            if (v16 && orv16) begin
                nb = 0;
                for (int w = 0; w < 4; w++) begin
                    dg = sc[w*4 +: 4];
                    if (dg != 4'd0) begin
                        b[nb] = {w[1:0], dg, rid, 1'b0};
                        nb++;
                    end
                end
                if (nb == 0 && lst) begin
                    q.push_back({2'd0, 4'd0, rid, 1'b1});
                end
                for (int k = 0; k < nb; k++) begin
                    q.push_back({b[k][22:1], lst && (k == nb - 1)});
                end
                pend = 1'b0;
                sent++;
            end
            step;
        end
        v16 = 1'b0;
        rdy = 1'b1;
        chk("rnd_sent", 32'(sent), 1000);
        chk("rnd_drained", 32'(q.size()), 0);
        step;
        chk("rnd_no_extra", 32'(ov16), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
